req_pending_ctrl: RTL and testbench
===================================

Name: req_pending_ctrl

Overview:
Upstream stage of the 8-input priority encoder. It captures single-cycle request pulses into sticky pending bits and presents the enabled pending vector to the encoder. It takes back the encoder's grant index and valid, and offers the winning index to a consumer over a valid/ready handshake. The serviced pending bit is cleared on acceptance.

Parameters:
NUM_REQ, 8, number of request lines; the encoder is fixed at 8, so only 8 is supported.
IDX_W, 3, index width, $clog2(NUM_REQ).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_pulse  input  NUM_REQ  request pulses; 1 = set pending bit
req_en  input  NUM_REQ  per-line enable; 1 = line visible to encoder
req_vec  output  NUM_REQ  pending & req_en, drives the encoder request input
enc_grant  input  IDX_W  encoder index (combinational from req_vec)
enc_valid  input  1  encoder valid
svc_valid  output  1  service offer valid
svc_id  output  IDX_W  offered index
svc_ready  input  1  consumer accepts offer
pending  output  NUM_REQ  raw sticky pending register, for status

Behaviour:
- Reset (async assert, sync release): pending=0, svc_valid=0, svc_id=0, state=IDLE. req_vec therefore resets to 0.
- Pending update each cycle: pending_next = (pending & ~clr_mask) | req_pulse.
  - clr_mask is one-hot at svc_id when svc_valid && svc_ready, else 0.
  - Set wins over clear: a pulse on the bit being cleared in the same cycle leaves it pending.
- req_vec = pending & req_en, combinational from registered pending and the input enable.
- FSM states:
  - IDLE: svc_valid=0. If enc_valid, latch svc_id<=enc_grant and go to OFFER.
  - OFFER: svc_valid=1. svc_id is held stable until the handshake.
    - svc_ready=1 → clear pending[svc_id] and go to IDLE.
    - Otherwise stay in OFFER.
- Latency: pulse at edge N → pending at N+1 → svc_valid at N+2. Minimum 1 idle cycle between offers, giving a throughput of 1 grant per 2 cycles.
- Mid-offer changes do not withdraw or re-prioritise the current offer. This covers a higher-priority pulse, disabling the offered line, or enc_valid dropping. Once raised, svc_valid stays high until accepted.
- Masked bits (req_en=0) remain pending and become visible when re-enabled.
- Pulse on an already-pending bit: absorbed; no count is kept.
- Reset mid-offer: svc_valid drops asynchronously and all pending bits are lost.
- svc_ready while in IDLE is ignored.

Optional Feature:
REQ_PEND_OVF_EN — when defined, the block adds two ports:
- ovf (output NUM_REQ): sticky flag per line, set when req_pulse hits a bit that is already pending and is not being cleared that cycle. Reset value 0.
- ovf_clr (input 1): clears all flags. A same-cycle set wins over ovf_clr.
When the macro is undefined, neither port exists and dropped duplicate pulses are silent.

Decomposition:
- Shared package req_pkg holds: NUM_REQ and IDX_W localparams, typedef req_vec_t (logic [NUM_REQ-1:0]), typedef req_idx_t (logic [IDX_W-1:0]), and enum svc_state_e {IDLE, OFFER}.
- One natural sub-module, req_sticky_reg: the pending register with set-over-clear and the optional overflow logic. The FSM stays in the top level.

Test Plan:
- Reset, then req_pulse=8'h24 for 1 cycle with req_en=8'hFF and the encoder model connected → req_vec=8'h24, then svc_valid=1 with svc_id=5 two edges after the pulse. Ready=1 → pending=8'h04; next offer svc_id=2; after acceptance pending=0.
- Offer svc_id=3 with svc_ready held 0 for 5 cycles while req_pulse=8'h80 arrives → svc_id stays 3 and svc_valid stays 1. After ready, next offer is 7.
- Handshake on id 4 in the same cycle as req_pulse=8'h10 → pending[4] remains 1 and a new offer with id 4 follows.
- req_en=8'h0F with pending=8'hF0 → svc_valid stays 0. Set req_en=8'hFF → offer svc_id=7.
- Assert rst_n=0 mid-offer → svc_valid, svc_id and pending go to 0 immediately, without waiting for a clock edge.
- With REQ_PEND_OVF_EN: pulse bit 1 twice while pending → ovf=8'h02. Pulse ovf_clr → 8'h00. Without the macro: same stimulus, no ovf port and identical service behaviour.

Source files
------------

// File: rtl/req_pending_ctrl_pkg.sv
// Shared types and constants for the request-pending front end of the 8-input encoder.
// Consumers: req_sticky_reg, req_pending_ctrl (optional overflow feature: REQ_PEND_OVF_EN).
package req_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = $clog2(NUM_REQ);

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   req_idx_t;

    typedef enum logic {
        IDLE,
        OFFER
    } svc_state_e;

    function automatic req_vec_t idx_onehot(input req_idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/req_pending_ctrl_sticky.sv
// Sticky pending register: set-over-clear per line, plus optional duplicate-pulse
// overflow flags when REQ_PEND_OVF_EN is defined.
module req_sticky_reg
    import req_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] set_mask,
    input  logic [NUM_REQ-1:0] clr_mask,
`ifdef REQ_PEND_OVF_EN
    input  logic               ovf_clr,
    output logic [NUM_REQ-1:0] ovf,
`endif
    output logic [NUM_REQ-1:0] pending
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

`ifdef REQ_PEND_OVF_EN
    req_vec_t ovf_set;

    // A pulse only overflows if the bit survives this cycle's clear.
    assign ovf_set = set_mask & pending & ~clr_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf_clr ? '0 : ovf) | ovf_set;
        end
    end
`endif

endmodule

// File: rtl/req_pending_ctrl.sv
// Request capture and service-offer FSM in front of the 8-input priority encoder.
// Optional overflow flags (ovf/ovf_clr) are present only when REQ_PEND_OVF_EN is defined.
module req_pending_ctrl
    import req_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic [NUM_REQ-1:0] req_en,
    output logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   enc_grant,
    input  logic               enc_valid,
    output logic               svc_valid,
    output logic [IDX_W-1:0]   svc_id,
    input  logic               svc_ready,
    output logic [NUM_REQ-1:0] pending
`ifdef REQ_PEND_OVF_EN
    ,
    output logic [NUM_REQ-1:0] ovf,
    input  logic               ovf_clr
`endif
);

    svc_state_e state;
    svc_state_e state_next;
    logic       load_id;
    logic       accept;
    req_vec_t   clr_mask;

    req_sticky_reg u_sticky (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_mask (req_pulse),
        .clr_mask (clr_mask),
`ifdef REQ_PEND_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .pending  (pending)
    );

    assign req_vec = pending & req_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An offer, once raised, is held regardless of encoder or enable changes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enc_valid) state_next = OFFER;
            OFFER:   if (svc_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        svc_valid = (state == OFFER);
        load_id   = (state == IDLE) && enc_valid;
        accept    = svc_valid && svc_ready;
        clr_mask  = accept ? idx_onehot(svc_id) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svc_id <= '0;
        end else if (load_id) begin
            svc_id <= enc_grant;
        end
    end

endmodule

// File: tb/tb_req_pending_ctrl.sv
// Self-checking bench for req_pending_ctrl: directed scenarios followed by random traffic,
// all compared against a behavioural model (overflow checks active with REQ_PEND_OVF_EN).
module tb_req_pending_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_pulse;
    logic [7:0] req_en;
    logic [7:0] req_vec;
    logic [2:0] enc_grant;
    logic       enc_valid;
    logic       svc_valid;
    logic [2:0] svc_id;
    logic       svc_ready;
    logic [7:0] pending;
`ifdef REQ_PEND_OVF_EN
    logic [7:0] ovf;
    logic       ovf_clr;
`endif

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [7:0] m_pend;
    logic [7:0] m_ovf;
    bit         m_busy;
    int         m_id;

    req_pending_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .req_en    (req_en),
        .req_vec   (req_vec),
        .enc_grant (enc_grant),
        .enc_valid (enc_valid),
        .svc_valid (svc_valid),
        .svc_id    (svc_id),
        .svc_ready (svc_ready),
        .pending   (pending)
`ifdef REQ_PEND_OVF_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External encoder: highest set index wins
    always_comb begin
        enc_valid = 1'b0;
        enc_grant = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req_vec[i]) begin
                enc_valid = 1'b1;
                enc_grant = 3'(i);
            end
        end
    end

    function automatic int top_bit(input logic [7:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00;
        m_ovf  = 8'h00;
        m_busy = 1'b0;
        m_id   = 0;
    endtask

    task automatic tick();
        logic [7:0] clr;
        logic [7:0] n_pend;
        logic [7:0] n_ovf;
        bit         n_busy;
        int         n_id;
        int         w;
        clr = 8'h00;
        if (m_busy && svc_ready) clr[m_id] = 1'b1;
        n_pend = (m_pend & ~clr) | req_pulse;
        n_ovf  = m_ovf;
`ifdef REQ_PEND_OVF_EN
        n_ovf = (ovf_clr ? 8'h00 : m_ovf) | (req_pulse & m_pend & ~clr);
`endif
        w      = top_bit(m_pend & req_en);
        n_busy = m_busy;
        n_id   = m_id;
        if (m_busy && svc_ready) n_busy = 1'b0;
        else if (!m_busy && w >= 0) begin
            n_busy = 1'b1;
            n_id   = w;
        end
        @(posedge clk);
        #1;
        m_pend = n_pend;
        m_ovf  = n_ovf;
        m_busy = n_busy;
        m_id   = n_id;
        chk("m_svc_valid", {7'b0, svc_valid}, {7'b0, m_busy});
        chk("m_svc_id", {5'b0, svc_id}, 8'(m_id));
        chk("m_pending", pending, m_pend);
        chk("m_req_vec", req_vec, m_pend & req_en);
`ifdef REQ_PEND_OVF_EN
        chk("m_ovf", ovf, m_ovf);
`endif
    endtask

    initial begin
        rst_n     = 1'b1;
        req_pulse = 8'h00;
        req_en    = 8'hFF;
        svc_ready = 1'b0;
`ifdef REQ_PEND_OVF_EN
        ovf_clr   = 1'b0;
`endif
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_svc_valid", {7'b0, svc_valid}, 8'h00);
        chk("rst_svc_id", {5'b0, svc_id}, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_req_vec", req_vec, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Two pulses served highest index first
        req_pulse = 8'h24;
        tick();
        req_pulse = 8'h00;
        chk("t1_req_vec", req_vec, 8'h24);
        tick();
        chk("t1_valid5", {7'b0, svc_valid}, 8'h01);
        chk("t1_id5", {5'b0, svc_id}, 8'h05);
        svc_ready = 1'b1;
        tick();
        chk("t1_pend04", pending, 8'h04);
        svc_ready = 1'b0;
        tick();
        chk("t1_id2", {5'b0, svc_id}, 8'h02);
        svc_ready = 1'b1;
        tick();
        chk("t1_pend00", pending, 8'h00);
        svc_ready = 1'b0;
        tick();

        // Back-pressure: higher-priority pulse must not re-prioritise the offer
        req_pulse = 8'h08;
        tick();
        req_pulse = 8'h00;
        tick();
        chk("t2_id3", {5'b0, svc_id}, 8'h03);
        req_pulse = 8'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            req_pulse = 8'h00;
            chk("t2_hold_valid", {7'b0, svc_valid}, 8'h01);
            chk("t2_hold_id", {5'b0, svc_id}, 8'h03);
        end
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        tick();
        chk("t2_id7", {5'b0, svc_id}, 8'h07);
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;

        // Set wins over clear on the accepted line
        req_pulse = 8'h10;
        tick();
        req_pulse = 8'h00;
        tick();
        chk("t3_id4", {5'b0, svc_id}, 8'h04);
        svc_ready = 1'b1;
        req_pulse = 8'h10;
        tick();
        chk("t3_pend10", pending, 8'h10);
        svc_ready = 1'b0;
        req_pulse = 8'h00;
        tick();
        chk("t3_reoffer_valid", {7'b0, svc_valid}, 8'h01);
        chk("t3_reoffer_id", {5'b0, svc_id}, 8'h04);
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        tick();

        // Masked lines stay pending until re-enabled
        req_en    = 8'h0F;
        req_pulse = 8'hF0;
        tick();
        req_pulse = 8'h00;
        tick();
        tick();
        chk("t4_masked_valid", {7'b0, svc_valid}, 8'h00);
        chk("t4_masked_pend", pending, 8'hF0);
        req_en = 8'hFF;
        tick();
        chk("t4_id7", {5'b0, svc_id}, 8'h07);
        svc_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        svc_ready = 1'b0;
        chk("t4_drained", pending, 8'h00);
        chk("t4_idle", {7'b0, svc_valid}, 8'h00);

        // Duplicate pulse while pending
        req_pulse = 8'h02;
        tick();
        tick();
        req_pulse = 8'h00;
`ifdef REQ_PEND_OVF_EN
        chk("t5_ovf02", ovf, 8'h02);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_ovf00", ovf, 8'h00);
`else
        tick();
`endif
        chk("t5_id1", {5'b0, svc_id}, 8'h01);
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        tick();
        chk("t5_pend00", pending, 8'h00);

        // Asynchronous reset during an offer
        req_pulse = 8'h40;
        tick();
        req_pulse = 8'h00;
        tick();
        chk("t6_id6", {5'b0, svc_id}, 8'h06);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {7'b0, svc_valid}, 8'h00);
        chk("t6_rst_id", {5'b0, svc_id}, 8'h00);
        chk("t6_rst_pend", pending, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            req_pulse = 8'($urandom) & 8'($urandom) & 8'($urandom);
            req_en    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            svc_ready = 1'($urandom);
`ifdef REQ_PEND_OVF_EN
            ovf_clr   = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
